bus_bridge_req_arbiter: RTL

//  Shares one bus-bridge request/response link between N_REQ requesters (bus_bridge_target_if

---
 rtl/bus_bridge_req_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bus_bridge_req_arbiter.sv
// bus_bridge_req_arbiter
//   Shares one bus-bridge request/response link between N_REQ requesters.
//   Round-robin arbitration feeds a single registered request stage. An in-order
//   ID FIFO remembers which requester owns each in-flight request so the in-order
//   link responses can be routed back to their owners.
//   Optional build macro: BUS_BRIDGE_ARB_STATS_EN adds per-requester saturating
//   16-bit grant counters on output grant_count.

package bus_bridge_pkg;
    typedef struct packed {
        logic        is_write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_bridge_req_t;

    typedef struct packed {
        logic        is_write;
        logic [7:0]  read_data;
    } bus_bridge_resp_t;
endpackage

module bus_bridge_req_arbiter
    import bus_bridge_pkg::*;
#(
    parameter  int N_REQ           = 2,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  s_req_valid,
    output logic [N_REQ-1:0]                  s_req_ready,
    input  bus_bridge_req_t [N_REQ-1:0]       s_req_payload,
    output logic [N_REQ-1:0]                  s_resp_valid,
    input  logic [N_REQ-1:0]                  s_resp_ready,
    output bus_bridge_resp_t                  s_resp_payload,
    output logic                              m_req_valid,
    input  logic                              m_req_ready,
    output bus_bridge_req_t                   m_req_payload,
    input  logic                              m_resp_valid,
    output logic                              m_resp_ready,
    input  bus_bridge_resp_t                  m_resp_payload,
`ifdef BUS_BRIDGE_ARB_STATS_EN
    output logic [N_REQ-1:0][15:0]            grant_count,
`endif
    output logic [CW-1:0]                     outstanding
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Registered link request stage and round-robin pointer
    logic                 r_m_req_valid;
    bus_bridge_req_t      r_m_req_payload;
    logic [IDW-1:0]       r_ptr;

    // ID FIFO state
    logic [IDW-1:0]       r_id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_can_issue;
    logic                 w_found;
    logic [IDW-1:0]       w_winner;
    logic [IDW-1:0]       w_cand;
    logic [N_REQ-1:0]     w_grant;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [IDW-1:0]       w_head;

    // A new request may enter the stage only if it is free or draining, and a FIFO
    // slot is free this cycle (a same-cycle pop does not count: no bypass).
    assign w_can_issue = (!r_m_req_valid || m_req_ready) &&
                         (r_count < CW'(MAX_OUTSTANDING));
    assign w_nonempty  = (r_count != '0);
    assign w_head      = r_id_mem[r_rd_ptr];
    assign w_push      = w_found;
    assign w_pop       = m_resp_valid && m_resp_ready;

    // Round-robin search starting one past the last winner, wrapping modulo N_REQ
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_grant  = '0;
        if (w_can_issue) begin
            for (int i = 1; i <= N_REQ; i++) begin
                w_cand = IDW'((int'(r_ptr) + i) % N_REQ);
                if (!w_found && s_req_valid[w_cand]) begin
                    w_found  = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
        if (w_found) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign s_req_ready = w_grant;

    // Route the link response to the owner at the FIFO head; stall if nothing is owed
    always_comb begin
        s_resp_valid = '0;
        m_resp_ready = 1'b0;
        if (w_nonempty) begin
            s_resp_valid[w_head] = m_resp_valid;
            m_resp_ready         = s_resp_ready[w_head];
        end
    end

    assign s_resp_payload = m_resp_payload;

    // Request stage: load on accept, hold while stalled, clear when drained
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_m_req_valid   <= 1'b0;
            r_m_req_payload <= '0;
            r_ptr           <= IDW'(N_REQ - 1);
        end else if (w_push) begin
            r_m_req_valid   <= 1'b1;
            r_m_req_payload <= s_req_payload[w_winner];
            r_ptr           <= w_winner;
        end else if (m_req_ready) begin
            r_m_req_valid   <= 1'b0;
        end
    end

    assign m_req_valid   = r_m_req_valid;
    assign m_req_payload = r_m_req_payload;

    // ID FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; entries are only read when occupancy says they were written.
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= w_winner;
        end
    end

    assign outstanding = r_count;

`ifdef BUS_BRIDGE_ARB_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant[i] && (grant_count[i] != 16'hFFFF)) begin
                    grant_count[i] <= grant_count[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
